// File: rtl/cache_request_bridge.sv
// cache_request_bridge: turns single-beat cache read/write requests into AXI4
// single-beat bursts, counts in-flight transactions and returns read data in
// R arrival order through a registered response stage.
// Optional build macro MEMORY_REQ_BYTE_STRB_EN adds the req_wstrb port; without
// it every write drives all byte strobes.
module cache_request_bridge #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int ID_W            = 8
) (
  input  logic            ap_clk,
  input  logic            areset,
  input  logic            cache_setup_signal,
  // request side
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [63:0]     req_addr,
  input  logic [ID_W-1:0] req_id,
  input  logic [511:0]    req_wdata,
`ifdef MEMORY_REQ_BYTE_STRB_EN
  input  logic [63:0]     req_wstrb,
`endif
  // read response side
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [ID_W-1:0] resp_id,
  output logic [511:0]    resp_rdata,
  output logic            resp_err,
  // AXI AR
  output logic            s_axi_arvalid,
  input  logic            s_axi_arready,
  output logic [63:0]     s_axi_araddr,
  output logic [7:0]      s_axi_arlen,
  output logic [ID_W-1:0] s_axi_arid,
  output logic [2:0]      s_axi_arsize,
  output logic [1:0]      s_axi_arburst,
  output logic            s_axi_arlock,
  output logic [3:0]      s_axi_arcache,
  output logic [2:0]      s_axi_arprot,
  output logic [3:0]      s_axi_arqos,
  // AXI R
  input  logic            s_axi_rvalid,
  output logic            s_axi_rready,
  input  logic [511:0]    s_axi_rdata,
  input  logic [ID_W-1:0] s_axi_rid,
  input  logic [1:0]      s_axi_rresp,
  input  logic            s_axi_rlast,
  // AXI AW
  output logic            s_axi_awvalid,
  input  logic            s_axi_awready,
  output logic [63:0]     s_axi_awaddr,
  output logic [7:0]      s_axi_awlen,
  output logic [ID_W-1:0] s_axi_awid,
  output logic [2:0]      s_axi_awsize,
  output logic [1:0]      s_axi_awburst,
  output logic            s_axi_awlock,
  output logic [3:0]      s_axi_awcache,
  output logic [2:0]      s_axi_awprot,
  output logic [3:0]      s_axi_awqos,
  // AXI W
  output logic            s_axi_wvalid,
  input  logic            s_axi_wready,
  output logic [511:0]    s_axi_wdata,
  output logic [63:0]     s_axi_wstrb,
  output logic            s_axi_wlast,
  // AXI B
  input  logic            s_axi_bvalid,
  output logic            s_axi_bready,
  input  logic [ID_W-1:0] s_axi_bid,
  input  logic [1:0]      s_axi_bresp,
  // status
  output logic [6:0]      outstanding
);

  typedef enum logic [1:0] {S_SETUP, S_READY, S_STALL} state_t;

  localparam logic [6:0] MAX_CNT = 7'(MAX_OUTSTANDING);

  state_t          state;
  logic            ar_v, aw_v, w_v;
  logic [62:0]     addr_q;
  logic [ID_W-1:0] id_q;
  logic [511:0]    wdata_q;
  logic [6:0]      cnt;
  logic            err_flag;
  logic            busy, accept, r_hs, b_err;
  logic [7:0]      cnt_inc, cnt_dec;
  logic            unused_inputs;

  assign busy    = ar_v | aw_v | w_v;
  assign req_ready = !areset && (state == S_READY) && !cache_setup_signal && !busy && (cnt < MAX_CNT);
  assign accept  = req_valid & req_ready;
  assign r_hs    = s_axi_rvalid & s_axi_rready;
  assign b_err   = s_axi_bvalid & (s_axi_bresp != 2'b00);
  assign cnt_inc = {1'b0, cnt} + 8'(accept);
  assign cnt_dec = 8'(r_hs) + 8'(s_axi_bvalid);

  assign outstanding = cnt;

  // Fixed single-beat burst attributes shared by both address channels.
  assign s_axi_arvalid = ar_v;
  assign s_axi_araddr  = {1'b0, addr_q};
  assign s_axi_arid    = id_q;
  assign s_axi_arlen   = '0;
  assign s_axi_arsize  = 3'b110;
  assign s_axi_arburst = 2'b01;
  assign s_axi_arlock  = 1'b0;
  assign s_axi_arcache = 4'b0011;
  assign s_axi_arprot  = '0;
  assign s_axi_arqos   = '0;
  assign s_axi_awvalid = aw_v;
  assign s_axi_awaddr  = {1'b0, addr_q};
  assign s_axi_awid    = id_q;
  assign s_axi_awlen   = '0;
  assign s_axi_awsize  = 3'b110;
  assign s_axi_awburst = 2'b01;
  assign s_axi_awlock  = 1'b0;
  assign s_axi_awcache = 4'b0011;
  assign s_axi_awprot  = '0;
  assign s_axi_awqos   = '0;
  assign s_axi_wvalid  = w_v;
  assign s_axi_wdata   = wdata_q;
  assign s_axi_wlast   = 1'b1;
  assign s_axi_bready  = 1'b1;
  assign s_axi_rready  = !resp_valid | resp_ready;

`ifdef MEMORY_REQ_BYTE_STRB_EN
  logic [63:0] wstrb_q;
  assign s_axi_wstrb = wstrb_q;
`else
  assign s_axi_wstrb = '1;
`endif

  // Single-beat bursts make rlast and bid redundant; bit 63 is never driven.
  assign unused_inputs = ^{s_axi_rlast, s_axi_bid, req_addr[63]};

  // Setup / ready / stall sequencing; setup only re-enters once fully drained.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state <= S_SETUP;
    end else begin
      case (state)
        S_SETUP: if (!cache_setup_signal) state <= S_READY;
        S_READY: begin
          if (cache_setup_signal && cnt == '0 && !busy) state <= S_SETUP;
          else if (cnt >= MAX_CNT)                      state <= S_STALL;
        end
        S_STALL: begin
          if (cache_setup_signal && cnt == '0 && !busy) state <= S_SETUP;
          else if (cnt < MAX_CNT)                       state <= S_READY;
        end
        default: state <= S_SETUP;
      endcase
    end
  end

  // Address/data valids: raised on acceptance, each dropped on its own ready.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      ar_v <= 1'b0;
      aw_v <= 1'b0;
      w_v  <= 1'b0;
    end else if (accept) begin
      ar_v <= !req_we;
      aw_v <= req_we;
      w_v  <= req_we;
    end else begin
      if (ar_v && s_axi_arready) ar_v <= 1'b0;
      if (aw_v && s_axi_awready) aw_v <= 1'b0;
      if (w_v && s_axi_wready)   w_v  <= 1'b0;
    end
  end

  // Only one request is ever pending, so AR and AW share the captured fields.
  always_ff @(posedge ap_clk) begin
    if (accept) begin
      addr_q  <= req_addr[62:0];
      id_q    <= req_id;
      wdata_q <= req_wdata;
`ifdef MEMORY_REQ_BYTE_STRB_EN
      wstrb_q <= req_wstrb;
`endif
    end
  end

  // In-flight count; clamps at zero so stray beats after reset cannot wrap it.
  always_ff @(posedge ap_clk) begin
    if (areset)                  cnt <= '0;
    else if (cnt_inc >= cnt_dec) cnt <= 7'(cnt_inc - cnt_dec);
    else                         cnt <= '0;
  end

  // Registered read response stage plus the sticky write-error flag; R beats
  // arriving with nothing in flight are consumed and dropped.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      err_flag   <= 1'b0;
    end else if (r_hs && cnt != '0) begin
      resp_valid <= 1'b1;
      resp_id    <= s_axi_rid;
      resp_rdata <= s_axi_rdata;
      resp_err   <= (s_axi_rresp != 2'b00) | err_flag;
      err_flag   <= b_err;
    end else begin
      if (resp_ready) resp_valid <= 1'b0;
      if (b_err)      err_flag   <= 1'b1;
    end
  end

endmodule
